if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end of the 5-stage RISC-V pipeline. Owns the PC register and issues
//  req/ack fetches to instruction memory. Holds one fetched instruction for decode under a
//  valid/ready handshake. Drives if_pc_plus4 into the next-PC mux2to1 (in0); the EX stage drives
//  in1 (branch/jump target) and sel. The mux output comes back on redirect_pc, with redirect_valid.
// PARAMETERS
//  XLEN      32            datapath/PC width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  NOP_INSTR 32'h0000_0013 if_instr value at reset (addi x0,x0,0)
// PORTS
//  clk             in   1     system clock, all state updates on rising edge
//  rst_n           in   1     synchronous reset, active-low
//  redirect_valid  in   1     taken branch/jump from EX; flush and reload PC
//  redirect_pc     in   XLEN  new PC (next-PC mux output); bits [1:0] forced to 0
//  imem_req        out  1     fetch request; held until imem_ack
//  imem_addr       out  XLEN  fetch address; stable while imem_req=1
//  imem_ack        in   1     memory returns imem_rdata this cycle; only valid while imem_req=1
//  imem_rdata      in   32    fetched instruction word
//  if_valid        out  1     if_instr/if_pc hold a live instruction for decode
//  if_ready_i      in   1     decode accepts; transfer when if_valid && if_ready_i
//  if_instr        out  32    fetched instruction
//  if_pc           out  XLEN  address of if_instr
//  if_pc_plus4     out  XLEN  imem_addr + 4, mod 2^XLEN; feeds next-PC mux in0
// BEHAVIOUR
//  Reset (rst_n=0 sampled at edge): state=IDLE, pc=RESET_PC, if_valid=0, if_instr=NOP_INSTR,
//   if_pc=0. imem_req=0, imem_addr=RESET_PC. Reset mid-request drops the outstanding fetch.
//   A late ack after reset is ignored.
//  imem_req = (state==REQ || state==SQUASH); imem_addr = pc (REQ) or squashed addr (SQUASH).
//  Buffer free: bfree = !if_valid || if_ready_i.
//  FSM:
//   IDLE   : redirect_valid -> pc<=redirect_pc, stay IDLE; else bfree -> REQ; else stay.
//   REQ    : ack && !redirect -> if_instr<=rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, -> IDLE.
//            ack && redirect -> discard rdata, pc<=redirect_pc, -> IDLE.
//            !ack && redirect -> latch sq_addr<=pc, pc<=redirect_pc, -> SQUASH.
//            !ack -> hold pc and imem_req.
//   SQUASH : req held on sq_addr until ack. On ack, discard rdata and go to IDLE.
//            redirect in SQUASH overwrites pc and stays.
//  Output buffer: if_valid clears on transfer (if_valid && if_ready_i) unless reloaded the same
//   cycle. redirect_valid clears if_valid next cycle regardless of if_ready_i, and has priority
//   over load. With if_ready_i=0, the buffer holds if_instr/if_pc stable.
//  Single outstanding fetch. Peak throughput is 1 instr / 2 cycles (ack latency 0).
//   First imem_req is asserted in the 2nd cycle after rst_n rises.
//  PC arithmetic: wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0); no carry out.
//  Memory never sees an address change or req drop before ack.
// TESTING
//  1 Reset, mem acks same cycle, if_ready_i=1 -> imem_addr 0,4,8,C on successive reqs;
//    if_pc 0,4,8 with if_valid pulses.
//  2 if_ready_i=0 for 5 cycles after first ack (rdata=32'h00500093) -> if_instr/if_pc=0 held,
//    no new imem_req issued.
//  3 Ack delayed 3 cycles, redirect_valid to 32'h100 in cycle 1 -> req stays on old addr until
//    ack, data dropped, next req addr 32'h100, if_valid never set for old data.
//  4 redirect_valid same cycle as ack -> rdata discarded, if_valid=0, next imem_addr=redirect_pc.
//  5 Redirect to 32'hFFFF_FFFC, then fetch -> if_pc_plus4=32'hFFFF_FFFC+4 = 0,
//    next imem_addr=0.
//  6 rst_n low while req outstanding -> next cycle imem_req=0, if_valid=0,
//    imem_addr=RESET_PC, if_instr=NOP.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch front end. Owns the PC, issues req/ack
//               fetches and holds one instruction for decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready_i,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  localparam logic [XLEN-1:0] c_PC_INC     = XLEN'(4);
  localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic [XLEN-1:0] r_sq_addr, w_sq_addr_next;
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_if_pc;
  logic            w_load;
  logic            w_bfree;
  logic [XLEN-1:0] w_redir_pc;

  assign w_bfree    = !r_valid || if_ready_i;
  assign w_redir_pc = redirect_pc & c_ALIGN_MASK;

  // A squashed fetch must stay on its original address until memory acks it.
  assign imem_req    = (r_state == ST_REQ) || (r_state == ST_SQUASH);
  assign imem_addr   = (r_state == ST_SQUASH) ? r_sq_addr : r_pc;
  assign if_pc_plus4 = imem_addr + c_PC_INC;

  assign if_valid = r_valid;
  assign if_instr = r_instr;
  assign if_pc    = r_if_pc;

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_sq_addr_next = r_sq_addr;
    w_load         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (redirect_valid) begin
          w_pc_next = w_redir_pc;
        end else if (w_bfree) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          w_state_next = ST_IDLE;
          if (redirect_valid) begin
            w_pc_next = w_redir_pc;
          end else begin
            w_load    = 1'b1;
            w_pc_next = r_pc + c_PC_INC;
          end
        end else if (redirect_valid) begin
          w_sq_addr_next = r_pc;
          w_pc_next      = w_redir_pc;
          w_state_next   = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        if (redirect_valid) begin
          w_pc_next = w_redir_pc;
        end
        if (imem_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_sq_addr <= RESET_PC;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_sq_addr <= w_sq_addr_next;
    end
  end

  // Redirect wins over both a same-cycle load and a pending transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_if_pc <= '0;
    end else if (redirect_valid) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_instr <= imem_rdata;
      r_if_pc <= r_pc;
    end else if (r_valid && if_ready_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready_i;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_checks = 0;
  int n_fails  = 0;

  if_fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_ready_i(if_ready_i),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    if_ready_i     = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_req",    {31'd0, imem_req}, 32'd0);
    check("rst_addr",   imem_addr,         32'h0);
    check("rst_valid",  {31'd0, if_valid}, 32'd0);
    check("rst_instr",  if_instr,          32'h0000_0013);
    check("rst_ifpc",   if_pc,             32'h0);
    check("rst_plus4",  if_pc_plus4,       32'h4);

    // 1: back-to-back fetches with same-cycle ack
    imem_ack = 1'b1;
    imem_rdata = 32'hA000_0000;
    tick();
    check("t1_req0",    {31'd0, imem_req}, 32'd1);
    check("t1_addr0",   imem_addr,         32'h0);
    tick();
    check("t1_valid0",  {31'd0, if_valid}, 32'd1);
    check("t1_instr0",  if_instr,          32'hA000_0000);
    check("t1_ifpc0",   if_pc,             32'h0);
    check("t1_idle0",   {31'd0, imem_req}, 32'd0);
    imem_rdata = 32'hA000_0001;
    tick();
    check("t1_addr1",   imem_addr,         32'h4);
    check("t1_xfer0",   {31'd0, if_valid}, 32'd0);
    imem_rdata = 32'hA000_0002;
    tick();
    check("t1_ifpc1",   if_pc,             32'h4);
    check("t1_instr1",  if_instr,          32'hA000_0002);
    tick();
    check("t1_addr2",   imem_addr,         32'h8);
    tick();
    check("t1_ifpc2",   if_pc,             32'h8);
    check("t1_valid2",  {31'd0, if_valid}, 32'd1);
    tick();
    check("t1_addr3",   imem_addr,         32'hC);
    check("t1_req3",    {31'd0, imem_req}, 32'd1);

    // 6: reset while a request is outstanding, then a late ack
    imem_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t6_req",     {31'd0, imem_req}, 32'd0);
    check("t6_valid",   {31'd0, if_valid}, 32'd0);
    check("t6_addr",    imem_addr,         32'h0);
    check("t6_instr",   if_instr,          32'h0000_0013);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    check("t6_late",    {31'd0, if_valid}, 32'd0);
    check("t6_req1",    {31'd0, imem_req}, 32'd1);

    // 2: decode stalls for 5 cycles after the first load
    do_reset();
    if_ready_i = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_req",   {31'd0, imem_req}, 32'd0);
      check("t2_valid", {31'd0, if_valid}, 32'd1);
      check("t2_instr", if_instr,          32'h0050_0093);
      check("t2_ifpc",  if_pc,             32'h0);
      tick();
    end
    if_ready_i = 1'b1;
    imem_ack = 1'b0;
    tick();
    check("t2_resume",  {31'd0, imem_req}, 32'd1);
    check("t2_addr",    imem_addr,         32'h4);
    check("t2_xfer",    {31'd0, if_valid}, 32'd0);

    // 3: redirect while the ack is delayed
    do_reset();
    tick();
    check("t3_req",     {31'd0, imem_req}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check("t3_sq_req",  {31'd0, imem_req}, 32'd1);
    check("t3_sq_addr", imem_addr,         32'h0);
    tick();
    check("t3_sq_hold", imem_addr,         32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_0003;
    tick();
    imem_ack = 1'b0;
    check("t3_drop",    {31'd0, if_valid}, 32'd0);
    check("t3_idle",    {31'd0, imem_req}, 32'd0);
    tick();
    check("t3_newaddr", imem_addr,         32'h100);
    check("t3_newreq",  {31'd0, imem_req}, 32'd1);
    check("t3_plus4",   if_pc_plus4,       32'h104);
    check("t3_novalid", {31'd0, if_valid}, 32'd0);

    // 4: redirect in the same cycle as ack
    do_reset();
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_0004;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    check("t4_valid",   {31'd0, if_valid}, 32'd0);
    check("t4_addr",    imem_addr,         32'h200);
    tick();
    check("t4_req",     {31'd0, imem_req}, 32'd1);
    check("t4_reqaddr", imem_addr,         32'h200);

    // 5: PC wrap at the top of the address space
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("t5_idle",    {31'd0, imem_req}, 32'd0);
    check("t5_addr",    imem_addr,         32'hFFFF_FFFC);
    check("t5_plus4",   if_pc_plus4,       32'h0);
    tick();
    check("t5_req",     {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("t5_ifpc",    if_pc,             32'hFFFF_FFFC);
    check("t5_wrap",    imem_addr,         32'h0);

    // Redirect flushes a held buffer even with decode stalled; low bits dropped
    if_ready_i = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    check("t5_flush",   {31'd0, if_valid}, 32'd0);
    check("t5_align",   imem_addr,         32'h40);
    if_ready_i = 1'b1;
    tick();
    check("t5_req2",    {31'd0, imem_req}, 32'd1);
    check("t5_addr2",   imem_addr,         32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
